// File: rtl/uart_prog_streamer_pkg.sv
// Shared types for the UART program streamer: controller FSM states,
// serialiser phases and the default bit period.
package uart_prog_streamer_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 87;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_FETCH,
    ST_LATCH,
    ST_CHECK,
    ST_SEND,
    ST_TERM,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_phase_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: a byte accepted while idle starts its start bit on the next cycle.
// byte_rdy_o is high only when idle, so one idle-high cycle always separates back-to-back frames.
module uart_tx_byte
  import uart_prog_streamer_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       byte_vld_i,
  input  logic [7:0] byte_dat_i,
  output logic       byte_rdy_o,
  output logic       tx_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  tx_phase_e        phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             bit_end;

  assign bit_end    = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign byte_rdy_o = (phase_q == TX_IDLE);
  assign tx_o       = tx_q;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    if (phase_q != TX_IDLE) cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    unique case (phase_q)
      TX_IDLE: begin
        if (byte_vld_i) begin
          phase_d = TX_START;
          shreg_d = byte_dat_i;
          cnt_d   = '0;
          tx_d    = 1'b0;
        end
      end
      TX_START: begin
        if (bit_end) begin
          phase_d = TX_DATA;
          bit_d   = '0;
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            phase_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end
      end
      TX_STOP: begin
        if (bit_end) phase_d = TX_IDLE;
      end
    endcase
  end

  // tx_q resets high asynchronously so a reset mid-frame idles the line at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/uart_prog_streamer.sv
// Streams program words from memory out of a UART until a terminator word or the word limit.
// Memory read latency 1 cycle; holds in WAIT_RDY while the synchronised target ready is low.
module uart_prog_streamer
  import uart_prog_streamer_pkg::*;
#(
  parameter int                    CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int                    WORD_BYTES   = 4,
  parameter int                    ADDR_W       = 14,
  parameter int                    MAX_WORDS    = 255,
  parameter logic [8*WORD_BYTES-1:0] TERM_WORD  = 'h00000FFF,
  parameter bit                    MSB_FIRST    = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    target_ready_i,
  output logic                    mem_req_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  input  logic [8*WORD_BYTES-1:0] mem_rdata_i,
  output logic                    tx_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [ADDR_W-1:0]       word_count_o
);

  localparam int                WORD_W  = 8 * WORD_BYTES;
  localparam int                BIDX_W  = $clog2(WORD_BYTES + 1);
  localparam logic [ADDR_W-1:0] MAX_CNT = ADDR_W'(MAX_WORDS);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [BIDX_W-1:0]   bidx_q, bidx_d;
  logic [1:0]          sync_q;
  logic                rdy_sync;
  logic                in_tx, word_sent;
  logic                tx_vld, tx_rdy;
  logic [BIDX_W-1:0]   sel;
  logic [7:0]          tx_dat;

  assign rdy_sync  = sync_q[1];
  assign in_tx     = (state_q == ST_SEND) || (state_q == ST_TERM);
  assign word_sent = (bidx_q == BIDX_W'(WORD_BYTES));
  assign tx_vld    = in_tx && !word_sent;
  assign sel       = MSB_FIRST ? BIDX_W'(WORD_BYTES - 1) - bidx_q : bidx_q;
  assign tx_dat    = 8'(word_q >> (8 * sel));

  assign mem_req_o    = (state_q == ST_FETCH);
  assign mem_addr_o   = addr_q;
  assign busy_o       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done_o       = (state_q == ST_DONE);
  assign word_count_o = cnt_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    bidx_d  = bidx_q;
    if (tx_vld && tx_rdy) bidx_d = bidx_q + 1'b1;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d = ST_WAIT_RDY;
          addr_d  = '0;
          cnt_d   = '0;
        end
      end
      ST_WAIT_RDY: if (rdy_sync) state_d = ST_FETCH;
      ST_FETCH:    state_d = ST_LATCH;
      ST_LATCH: begin
        word_d  = mem_rdata_i;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        bidx_d = '0;
        if ((word_q == TERM_WORD) || (cnt_q == MAX_CNT)) begin
          word_d  = TERM_WORD;
          state_d = ST_TERM;
        end else begin
          state_d = ST_SEND;
        end
      end
      // A word is finished only once its last stop bit has left the line.
      ST_SEND: begin
        if (word_sent && tx_rdy) begin
          addr_d  = addr_q + 1'b1;
          cnt_d   = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 1'b1;
          state_d = rdy_sync ? ST_FETCH : ST_WAIT_RDY;
        end
      end
      ST_TERM: if (word_sent && tx_rdy) state_d = ST_DONE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      bidx_q  <= '0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      bidx_q  <= bidx_d;
      sync_q  <= {sync_q[0], target_ready_i};
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .byte_vld_i(tx_vld),
    .byte_dat_i(tx_dat),
    .byte_rdy_o(tx_rdy),
    .tx_o      (tx_o)
  );

endmodule

// File: tb/tb_uart_prog_streamer.sv
// Directed bench for uart_prog_streamer: an MSB-first and an LSB-first instance,
// each with a small program memory and a UART frame decoder on tx_o.
module tb_uart_prog_streamer;

  localparam int C     = 4;
  localparam int FRAME = 10 * C;

  typedef struct {
    logic [7:0] b;
    int         gap;
    bit         ok;
  } rx_t;

  typedef struct {
    int           ch;
    logic [127:0] words;
    int           nbytes;
    logic [127:0] exp;
    int           cnt;
    string        name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_s [2];
  logic        rdy_s   [2];
  logic        req_s   [2];
  logic        tx_s    [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic [13:0] addr_s  [2];
  logic [13:0] cnt_s   [2];
  logic [31:0] rdata_s [2];
  logic [31:0] mem     [2][16];
  int          checks = 0;
  int          errors = 0;

  initial forever #5 clk = ~clk;

  uart_prog_streamer #(.CLKS_PER_BIT(C), .MAX_WORDS(3), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_s[0]), .target_ready_i(rdy_s[0]),
    .mem_req_o(req_s[0]), .mem_addr_o(addr_s[0]), .mem_rdata_i(rdata_s[0]),
    .tx_o(tx_s[0]), .busy_o(busy_s[0]), .done_o(done_s[0]), .word_count_o(cnt_s[0]));

  uart_prog_streamer #(.CLKS_PER_BIT(C), .MAX_WORDS(3), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_s[1]), .target_ready_i(rdy_s[1]),
    .mem_req_o(req_s[1]), .mem_addr_o(addr_s[1]), .mem_rdata_i(rdata_s[1]),
    .tx_o(tx_s[1]), .busy_o(busy_s[1]), .done_o(done_s[1]), .word_count_o(cnt_s[1]));

  // Program memory: data valid the cycle after the request.
  always @(posedge clk)
    for (int k = 0; k < 2; k++)
      if (req_s[k]) rdata_s[k] <= mem[k][addr_s[k][3:0]];

  // Frame decoder: every bit window must be constant, start 0, stop 1.
  for (genvar g = 0; g < 2; g++) begin : g_ch
    rx_t q[$];
    initial begin : mon
      int               n;
      int               gap;
      bit               in_f;
      logic [FRAME-1:0] fr;
      n = 0; gap = 0; in_f = 0; fr = '0;
      forever begin
        @(negedge clk);
        if (rst_n !== 1'b1) begin
          in_f = 0;
          gap  = 0;
        end else if (!in_f) begin
          if (tx_s[g] === 1'b0) begin
            in_f = 1; fr = '0; n = 1;
          end else begin
            gap++;
          end
        end else begin
          fr[n] = tx_s[g];
          n++;
          if (n == FRAME) begin
            rx_t r;
            r.ok = 1; r.gap = gap; r.b = '0;
            for (int k = 0; k < 10; k++)
              for (int j = 1; j < C; j++)
                if (fr[k*C+j] !== fr[k*C]) r.ok = 0;
            if (fr[9*C] !== 1'b1) r.ok = 0;
            for (int k = 0; k < 8; k++) r.b[k] = fr[(k+1)*C];
            q.push_back(r);
            in_f = 0;
            gap  = 0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_ge(input string name, input int act, input int lo);
    checks++;
    if (act < lo) begin
      errors++;
      $display("FAIL %s: got %0d, expected >= %0d", name, act, lo);
    end
  endtask

  function automatic int rx_size(input int ch);
    if (ch == 0) return g_ch[0].q.size();
    return g_ch[1].q.size();
  endfunction

  function automatic rx_t rx_get(input int ch, input int i);
    if (ch == 0) return g_ch[0].q[i];
    return g_ch[1].q[i];
  endfunction

  task automatic load_mem(input int ch, input logic [127:0] words);
    for (int i = 0; i < 16; i++)
      mem[ch][i] = (i < 4) ? words[127-32*i -: 32] : 32'h0;
  endtask

  task automatic pulse_start(input int ch);
    @(negedge clk);
    if (ch == 0) g_ch[0].q.delete();
    else         g_ch[1].q.delete();
    start_s[ch] = 1'b1;
    @(negedge clk);
    start_s[ch] = 1'b0;
  endtask

  task automatic wait_done(input int ch, input string name);
    int n = 0;
    while (done_s[ch] !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk({name, " done"}, done_s[ch], 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_rx(input int ch, input int nbytes, input logic [127:0] exp,
                          input int cnt, input string name);
    int n = rx_size(ch);
    chk({name, " nbytes"}, n, nbytes);
    for (int i = 0; i < nbytes && i < n; i++) begin
      rx_t r = rx_get(ch, i);
      chk($sformatf("%s byte%0d", name, i), r.b, exp[127-8*i -: 8]);
      chk($sformatf("%s frame%0d", name, i), r.ok, 1);
      if (i > 0) begin
        if (i % 4 != 0) chk($sformatf("%s gap%0d", name, i), r.gap, 1);
        else            chk_ge($sformatf("%s gap%0d", name, i), r.gap, 3);
      end
    end
    chk({name, " busy"}, busy_s[ch], 0);
    chk({name, " count"}, cnt_s[ch], cnt);
  endtask

  initial begin
    vec_t vecs[6];
    int   bad;
    int   n;
    vecs[0] = '{0, 128'h12345678_00000FFF_00000000_00000000, 8,
                   128'h12345678_00000FFF_00000000_00000000, 1, "msb_basic"};
    vecs[1] = '{1, 128'hA1B2C3D4_00000FFF_00000000_00000000, 8,
                   128'hD4C3B2A1_FF0F0000_00000000_00000000, 1, "lsb_basic"};
    vecs[2] = '{0, 128'h11111111_22222222_33333333_44444444, 16,
                   128'h11111111_22222222_33333333_00000FFF, 3, "msb_maxwords"};
    vecs[3] = '{0, 128'h00000FFF_12345678_00000000_00000000, 4,
                   128'h00000FFF_00000000_00000000_00000000, 0, "msb_term_only"};
    vecs[4] = '{1, 128'hDEADBEEF_00000FFF_00000000_00000000, 8,
                   128'hEFBEADDE_FF0F0000_00000000_00000000, 1, "lsb_deadbeef"};
    vecs[5] = '{1, 128'h01020304_05060708_090A0B0C_0D0E0F10, 16,
                   128'h04030201_08070605_0C0B0A09_FF0F0000, 3, "lsb_maxwords"};

    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start_s[k] = 1'b0;
      rdy_s[k]   = 1'b1;
      load_mem(k, 128'h0);
    end
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset tx", tx_s[0], 1);
    chk("reset tx lsb", tx_s[1], 1);
    chk("reset mem_req", req_s[0], 0);
    chk("reset mem_addr", addr_s[0], 0);
    chk("reset busy", busy_s[0], 0);
    chk("reset done", done_s[0], 0);
    chk("reset count", cnt_s[0], 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      load_mem(vecs[v].ch, vecs[v].words);
      pulse_start(vecs[v].ch);
      wait_done(vecs[v].ch, vecs[v].name);
      check_rx(vecs[v].ch, vecs[v].nbytes, vecs[v].exp, vecs[v].cnt, vecs[v].name);
    end

    // Ready held low after start: line quiet, no fetch, then a delayed first frame.
    load_mem(0, 128'h12345678_00000FFF_00000000_00000000);
    rdy_s[0] = 1'b0;
    pulse_start(0);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_s[0] !== 1'b1 || req_s[0] !== 1'b0) bad++;
    end
    chk("rdy_low quiet", bad, 0);
    chk("rdy_low busy", busy_s[0], 1);
    rdy_s[0] = 1'b1;
    n = 0;
    while (tx_s[0] !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rdy_low start seen", tx_s[0], 0);
    chk_ge("rdy_low start delay", n, 3);
    wait_done(0, "rdy_low");
    check_rx(0, 8, 128'h12345678_00000FFF_00000000_00000000, 1, "rdy_low");

    // Ready drops mid-word: the word finishes, then the streamer parks.
    load_mem(0, 128'h11111111_22222222_00000FFF_00000000);
    pulse_start(0);
    repeat (60) @(negedge clk);
    rdy_s[0] = 1'b0;
    repeat (250) @(negedge clk);
    chk("rdy_drop bytes", rx_size(0), 4);
    chk("rdy_drop busy", busy_s[0], 1);
    chk("rdy_drop addr", addr_s[0], 1);
    chk("rdy_drop count", cnt_s[0], 1);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx_s[0] !== 1'b1 || req_s[0] !== 1'b0) bad++;
    end
    chk("rdy_drop parked", bad, 0);
    rdy_s[0] = 1'b1;
    wait_done(0, "rdy_drop");
    check_rx(0, 12, 128'h11111111_22222222_00000FFF_00000000, 2, "rdy_drop");

    // Reset during data bit 1 of the first byte (0x55: bit 1 is low).
    load_mem(0, 128'h55AA0102_00000FFF_00000000_00000000);
    pulse_start(0);
    n = 0;
    while (tx_s[0] !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid start seen", tx_s[0], 0);
    repeat (2 * C) @(negedge clk);
    chk("rst_mid bit1 low", tx_s[0], 0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid tx", tx_s[0], 1);
    chk("rst_mid busy", busy_s[0], 0);
    chk("rst_mid mem_req", req_s[0], 0);
    chk("rst_mid done", done_s[0], 0);
    chk("rst_mid count", cnt_s[0], 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx_s[0] !== 1'b1 || busy_s[0] !== 1'b0) bad++;
    end
    chk("rst_mid no resume", bad, 0);
    pulse_start(0);
    n = 0;
    while (req_s[0] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid first req", req_s[0], 1);
    chk("rst_mid first addr", addr_s[0], 0);
    wait_done(0, "rst_mid");
    check_rx(0, 8, 128'h55AA0102_00000FFF_00000000_00000000, 1, "rst_mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_prog_streamer.md
UART_PROG_STREAMER -- requirements
Module: uart_prog_streamer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, clocks per UART bit (minimum 4).
REQ-002 SHALL have parameter WORD_BYTES, default 4, bytes per program word (1..8).
REQ-003 SHALL have parameter ADDR_W, default 14, word-address width of the program memory.
REQ-004 SHALL have parameter MAX_WORDS, default 255, word limit before forced termination.
REQ-005 SHALL have parameter TERM_WORD, default 'h00000FFF, width 8*WORD_BYTES, the end-of-program marker.
REQ-006 SHALL have parameter MSB_FIRST, default 1; 1 = most-significant byte first, 0 = least-significant byte first.
REQ-007 clk_i  in  1  single clock, all state on rising edge.
REQ-008 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-009 start_i  in  1  one-cycle pulse that launches a download; ignored unless IDLE or DONE.
REQ-010 target_ready_i  in  1  asynchronous target-ready level.
REQ-011 mem_req_o  out  1  one-cycle read strobe.
REQ-012 mem_addr_o  out  ADDR_W  word address.
REQ-013 mem_rdata_i  in  8*WORD_BYTES  read data, valid exactly 1 cycle after mem_req_o.
REQ-014 tx_o  out  1  UART serial line, 8N1, idle high.
REQ-015 busy_o  out  1  high in any state other than IDLE or DONE.
REQ-016 done_o  out  1  high in DONE.
REQ-017 word_count_o  out  ADDR_W  number of payload words fully sent.

Function
REQ-018 SHALL implement the FSM states IDLE, WAIT_RDY, FETCH, LATCH, CHECK, SEND, TERM, and DONE.
REQ-019 IDLE/DONE -> WAIT_RDY on start_i, clearing word_count_o and the address.
REQ-020 SHALL pass target_ready_i through a 2-flop synchroniser; WAIT_RDY -> FETCH on the first cycle the synchronised ready is high.
REQ-021 FETCH SHALL assert mem_req_o for 1 cycle with mem_addr_o = current address -> LATCH.
REQ-022 LATCH SHALL capture mem_rdata_i into the word register -> CHECK.
REQ-023 CHECK: if word == TERM_WORD or word_count_o == MAX_WORDS -> TERM; else -> SEND.
REQ-024 SEND SHALL transmit WORD_BYTES bytes in MSB_FIRST order, then increment word_count_o and the address -> FETCH.
REQ-025 TERM SHALL load TERM_WORD and transmit it in the same byte order -> DONE; the terminator SHALL NOT be counted.
REQ-026 Each byte SHALL be a start bit (0), 8 data bits LSB first, and a stop bit (1), each held exactly CLKS_PER_BIT cycles.
REQ-027 Between bytes of a word, tx_o SHALL stay high for exactly 1 cycle; between words, for at least 3 cycles (FETCH, LATCH, CHECK).
REQ-028 Address arithmetic SHALL wrap modulo 2^ADDR_W; word_count_o SHALL saturate at MAX_WORDS.
REQ-029 If synchronised ready drops during SEND, the current word SHALL complete, and the FSM SHALL return to WAIT_RDY before the next FETCH.
REQ-030 start_i while busy_o is high SHALL have no effect.

Reset
REQ-031 On rst_ni low: state IDLE, tx_o=1, mem_req_o=0, mem_addr_o=0, busy_o=0, done_o=0, word_count_o=0, synchroniser flops 0.
REQ-032 Reset mid-byte SHALL force tx_o high immediately (asynchronously); no partial frame SHALL resume after release.

Structure
REQ-033 A shared package SHALL hold the FSM state enum and the default bit-period constant.
REQ-034 Byte serialisation SHALL live in a sub-module uart_tx_byte (valid/ready byte input, tx output, own bit-period counter and bit index).

Verification
REQ-035 CLKS_PER_BIT=4, memory {12345678, 00000FFF}, ready high, start -> bytes 12,34,56,78,00,00,0F,FF on tx_o; done_o=1; word_count_o=1.
REQ-036 MSB_FIRST=0, memory {A1B2C3D4, 00000FFF} -> bytes D4,C3,B2,A1,FF,0F,00,00.
REQ-037 MAX_WORDS=3, memory without a terminator -> exactly 3 words, then the terminator; word_count_o=3.
REQ-038 ready held low 50 cycles after start -> tx_o high and mem_req_o=0 throughout; the first start bit appears no earlier than 3 cycles after ready rises.
REQ-039 rst_ni pulsed low during the second data bit -> tx_o=1 on the same edge, state IDLE; a new start_i resends from address 0.
REQ-040 Every bit measured -> exactly CLKS_PER_BIT cycles; each frame has start 0 and stop 1.
